spi_peripheral: RTL and testbench
=================================

SPI_PERIPHERAL -- requirements
Module: spi_peripheral

Interface
REQ-001 SHALL have port i_clk, input, 1, system clock; all logic on its rising edge.
REQ-002 SHALL have port i_rst, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port i_mode, input, 2, SPI mode: bit1 = CPOL, bit0 = CPHA; sampled only while i_cs_n is high.
REQ-004 SHALL have port i_sclk, input, 1, serial clock from controller, asynchronous to i_clk.
REQ-005 SHALL have port i_cs_n, input, 1, active-low chip select, asynchronous.
REQ-006 SHALL have port i_copi, input, 1, controller-out data, asynchronous.
REQ-007 SHALL have port o_cipo, output, 1, controller-in data, MSB first.
REQ-008 SHALL have port o_cipo_oe, output, 1, output enable for o_cipo; high only while synchronized chip select is asserted.
REQ-009 SHALL have ports i_tx_data (input, 8, next byte to send) and i_tx_load (input, 1, write strobe for i_tx_data).
REQ-010 SHALL have port o_tx_ready, output, 1, high when the TX holding buffer is empty.
REQ-011 SHALL have ports o_rx_data (output, 8, last received byte) and o_rx_valid (output, 1, one-cycle pulse on byte completion).
REQ-012 SHALL have port o_busy, output, 1, high while a frame is in progress (synchronized chip select low).

Function
REQ-013 SHALL pass i_sclk, i_cs_n and i_copi through 2-flop synchronizers, then register them once more for edge detection.
REQ-014 SHALL support i_sclk up to i_clk/8; faster clocks are outside the specification.
REQ-015 SHALL define the leading edge as the first sclk transition away from CPOL, and the trailing edge as the return to CPOL.
REQ-016 SHALL behave as follows when CPHA=0: sample i_copi on leading edges, shift o_cipo on trailing edges, and present bit 7 on o_cipo in the cycle after the chip-select fall is detected.
REQ-017 SHALL behave as follows when CPHA=1: shift o_cipo on leading edges (the first leading edge presents bit 7) and sample on trailing edges.
REQ-018 SHALL use an FSM with states IDLE, LOAD, SHIFT, DONE: IDLE->LOAD on detected chip-select fall; LOAD (1 cycle) moves buffer to shift register, ->SHIFT; SHIFT->DONE after 8th sample; DONE (1 cycle) ->LOAD if chip select is still low, else IDLE.
REQ-019 SHALL, in DONE, update o_rx_data and pulse o_rx_valid for exactly one cycle; o_rx_data holds until the next DONE.
REQ-020 SHALL maintain a 3-bit bit counter that wraps 7->0, allowing back-to-back bytes within one chip-select assertion.
REQ-021 SHALL, on i_tx_load while o_tx_ready is high, capture i_tx_data and drop o_tx_ready the next cycle; i_tx_load while o_tx_ready is low is ignored.
REQ-022 SHALL, in LOAD, set o_tx_ready again; if the buffer is empty, shift out 0x00.
REQ-023 SHALL, on a chip-select rise during SHIFT, abort: discard the partial byte, produce no o_rx_valid, clear the bit counter, and go to IDLE.
REQ-024 SHALL let i_tx_load in the same cycle as LOAD update the buffer after the transfer, so the loaded byte is used for the next byte.

Reset
REQ-025 SHALL, on i_rst asserted, immediately force: FSM=IDLE, o_cipo=0, o_cipo_oe=0, o_tx_ready=1, o_rx_data=0x00, o_rx_valid=0, o_busy=0, counters and synchronizers cleared (chip-select synchronizer flops to 1).
REQ-026 SHALL, on reset asserted mid-frame, discard the frame; after release, wait for a fresh chip-select fall.

Configuration
REQ-027 SHALL, with macro SPI_PERIPHERAL_UNDERRUN_EN defined, provide output o_tx_underrun (1 bit) that goes high in LOAD when the buffer is empty, stays high, and clears on an accepted i_tx_load or on reset.
REQ-028 SHALL, without SPI_PERIPHERAL_UNDERRUN_EN, omit o_tx_underrun and its logic; all other behaviour is identical.

Verification
REQ-029 SHALL cover: mode 0, sclk=i_clk/8, tx buffer 0x3C, controller sends 0xA5 -> o_rx_data=0xA5 with a one-cycle o_rx_valid; controller receives 0x3C.
REQ-030 SHALL cover: modes 1, 2 and 3 each, controller sends 0x5A, buffer 0xC3 -> 0x5A received, 0xC3 returned, with no bit skew.
REQ-031 SHALL cover: one chip-select assertion, two bytes 0x11 then 0x22, buffer reloaded 0x81 then 0x42 -> two o_rx_valid pulses (0x11, 0x22); controller receives 0x81, 0x42.
REQ-032 SHALL cover: chip select raised after 4 sclk edges -> no o_rx_valid, o_rx_data unchanged, next full frame 0xF0 received correctly.
REQ-033 SHALL cover: i_rst pulsed mid-byte -> all outputs at reset values within the same cycle; subsequent frame 0x96 correct.
REQ-034 SHALL cover, with SPI_PERIPHERAL_UNDERRUN_EN: frame with no buffer load -> 0x00 shifted out, o_tx_underrun=1, cleared by the next i_tx_load.

Source files
------------

// File: rtl/spi_peripheral_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_peripheral_if
// Description : Pin and host-side bundle for spi_peripheral. o_tx_underrun
//               is present only when SPI_PERIPHERAL_UNDERRUN_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_peripheral_if;
   logic [1:0] i_mode;
   logic       i_sclk;
   logic       i_cs_n;
   logic       i_copi;
   logic       o_cipo;
   logic       o_cipo_oe;
   logic [7:0] i_tx_data;
   logic       i_tx_load;
   logic       o_tx_ready;
   logic [7:0] o_rx_data;
   logic       o_rx_valid;
   logic       o_busy;
`ifdef SPI_PERIPHERAL_UNDERRUN_EN
   logic       o_tx_underrun;
`endif

   modport slave (
      input  i_mode, i_sclk, i_cs_n, i_copi, i_tx_data, i_tx_load,
      output o_cipo, o_cipo_oe, o_tx_ready, o_rx_data, o_rx_valid, o_busy
`ifdef SPI_PERIPHERAL_UNDERRUN_EN
      , output o_tx_underrun
`endif
   );

   modport master (
      output i_mode, i_sclk, i_cs_n, i_copi, i_tx_data, i_tx_load,
      input  o_cipo, o_cipo_oe, o_tx_ready, o_rx_data, o_rx_valid, o_busy
`ifdef SPI_PERIPHERAL_UNDERRUN_EN
      , input o_tx_underrun
`endif
   );
endinterface
`default_nettype wire

// File: rtl/spi_peripheral.sv
`default_nettype none
// ============================================================================
// Module      : spi_peripheral
// Description : SPI peripheral (modes 0-3) oversampled in the i_clk domain,
//               with one-byte TX holding buffer and back-to-back byte support.
//               Optional macro SPI_PERIPHERAL_UNDERRUN_EN adds o_tx_underrun.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_peripheral (
   input  logic            i_clk,
   input  logic            i_rst,
   spi_peripheral_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t     r_state;
   state_t     w_state_nxt;

   logic       r_sclk_s1, r_sclk_s2, r_sclk_d;
   logic       r_cs_s1, r_cs_s2, r_cs_d;
   logic       r_copi_s1, r_copi_s2, r_copi_d;
   logic [1:0] r_sync_fill;
   logic       r_armed;
   logic [1:0] r_mode;

   logic [7:0] r_tx_buf;
   logic       r_tx_full;
   logic [7:0] r_tx_sr;
   logic       r_cipo;
   logic [6:0] r_rx_sr;
   logic [2:0] r_bit_cnt;
   logic [7:0] r_rx_data;
   logic       r_rx_valid;

   logic       w_cpol, w_cpha;
   logic       w_sclk_rise, w_sclk_fall;
   logic       w_lead, w_trail;
   logic       w_sample, w_shift;
   logic       w_cs_fall;
   logic       w_accept;
   logic       w_last_bit;
   logic [7:0] w_load_byte;

   assign w_cpol      = r_mode[1];
   assign w_cpha      = r_mode[0];
   assign w_sclk_rise = r_sclk_s2 & ~r_sclk_d;
   assign w_sclk_fall = ~r_sclk_s2 & r_sclk_d;
   assign w_lead      = w_cpol ? w_sclk_fall : w_sclk_rise;
   assign w_trail     = w_cpol ? w_sclk_rise : w_sclk_fall;
   assign w_sample    = w_cpha ? w_trail : w_lead;
   // CPHA=0: the first trailing edge seen in a byte belongs to the previous byte
   assign w_shift     = w_cpha ? w_lead : (w_trail & (r_bit_cnt != 3'd0));
   assign w_cs_fall   = r_armed & ~r_cs_s2 & r_cs_d;
   assign w_accept    = bus.i_tx_load & ~r_tx_full;
   assign w_last_bit  = (r_bit_cnt == 3'd7);
   assign w_load_byte = r_tx_full ? r_tx_buf : 8'h00;

   // Input synchronizers plus edge-detect stage
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sclk_s1 <= 1'b0;
         r_sclk_s2 <= 1'b0;
         r_sclk_d  <= 1'b0;
         r_cs_s1   <= 1'b1;
         r_cs_s2   <= 1'b1;
         r_cs_d    <= 1'b1;
         r_copi_s1 <= 1'b0;
         r_copi_s2 <= 1'b0;
         r_copi_d  <= 1'b0;
      end else begin
         r_sclk_s1 <= bus.i_sclk;
         r_sclk_s2 <= r_sclk_s1;
         r_sclk_d  <= r_sclk_s2;
         r_cs_s1   <= bus.i_cs_n;
         r_cs_s2   <= r_cs_s1;
         r_cs_d    <= r_cs_s2;
         r_copi_s1 <= bus.i_copi;
         r_copi_s2 <= r_copi_s1;
         r_copi_d  <= r_copi_s2;
      end
   end

   // Chip select must be seen genuinely high after reset before a fall counts,
   // so a frame interrupted by reset is never picked up halfway through.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_sync_fill <= 2'd0;
         r_armed     <= 1'b0;
         r_mode      <= 2'b00;
      end else begin
         if (r_sync_fill != 2'd3)
            r_sync_fill <= r_sync_fill + 2'd1;
         if ((r_sync_fill == 2'd3) && r_cs_s2)
            r_armed <= 1'b1;
         if (r_cs_s2)
            r_mode <= bus.i_mode;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r_state <= IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (w_cs_fall) w_state_nxt = LOAD;
         LOAD:    w_state_nxt = SHIFT;
         SHIFT: begin
            if (r_cs_s2)
               w_state_nxt = IDLE;
            else if (w_sample && w_last_bit)
               w_state_nxt = DONE;
         end
         DONE:    w_state_nxt = r_cs_s2 ? IDLE : LOAD;
         default: w_state_nxt = IDLE;
      endcase
   end

   // TX holding buffer; a load accepted during LOAD lands after the transfer
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_tx_buf  <= 8'h00;
         r_tx_full <= 1'b0;
      end else begin
         if (w_accept)
            r_tx_buf <= bus.i_tx_data;
         r_tx_full <= w_accept | (r_tx_full & (r_state != LOAD));
      end
   end

   // Shift datapath
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_tx_sr    <= 8'h00;
         r_cipo     <= 1'b0;
         r_rx_sr    <= 7'h00;
         r_bit_cnt  <= 3'd0;
         r_rx_data  <= 8'h00;
         r_rx_valid <= 1'b0;
      end else begin
         r_rx_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               r_cipo    <= 1'b0;
               r_bit_cnt <= 3'd0;
            end
            LOAD: begin
               r_bit_cnt <= 3'd0;
               if (w_cpha) begin
                  r_tx_sr <= w_load_byte;
               end else begin
                  r_cipo  <= w_load_byte[7];
                  r_tx_sr <= {w_load_byte[6:0], 1'b0};
               end
            end
            SHIFT: begin
               if (r_cs_s2) begin
                  r_bit_cnt <= 3'd0;
               end else begin
                  if (w_shift) begin
                     r_cipo  <= r_tx_sr[7];
                     r_tx_sr <= {r_tx_sr[6:0], 1'b0};
                  end
                  if (w_sample) begin
                     r_rx_sr   <= {r_rx_sr[5:0], r_copi_d};
                     r_bit_cnt <= r_bit_cnt + 3'd1;
                     if (w_last_bit) begin
                        r_rx_data  <= {r_rx_sr, r_copi_d};
                        r_rx_valid <= 1'b1;
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

`ifdef SPI_PERIPHERAL_UNDERRUN_EN
   logic r_tx_underrun;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r_tx_underrun <= 1'b0;
      else if ((r_state == LOAD) && !r_tx_full)
         r_tx_underrun <= 1'b1;
      else if (w_accept)
         r_tx_underrun <= 1'b0;
   end

   assign bus.o_tx_underrun = r_tx_underrun;
`endif

   // CPHA=0 needs bit 7 visible while LOAD is still transferring the buffer
   assign bus.o_cipo     = ((r_state == LOAD) && !w_cpha) ? w_load_byte[7] : r_cipo;
   assign bus.o_cipo_oe  = r_armed & ~r_cs_s2;
   assign bus.o_busy     = r_armed & ~r_cs_s2;
   assign bus.o_tx_ready = ~r_tx_full;
   assign bus.o_rx_data  = r_rx_data;
   assign bus.o_rx_valid = r_rx_valid;

endmodule
`default_nettype wire

// File: tb/tb_spi_peripheral.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_peripheral
// Description : Bench for spi_peripheral: bit-banged SPI controller plus a
//               byte-slot model of the TX buffer and the received bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_peripheral;
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   spi_peripheral_if bus ();
   spi_peripheral dut (.i_clk(clk), .i_rst(rst), .bus(bus.slave));

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: every byte slot takes the buffer (or 0x00 if empty)
   logic [7:0] m_buf = 8'h00;
   bit         m_full = 1'b0;
   logic [7:0] m_slot = 8'h00;
   logic [7:0] m_rx_data = 8'h00;
   bit         m_underrun = 1'b0;

   logic [7:0] rx_q[$];
   int         wide_pulses = 0;
   logic       prev_valid = 1'b0;

   always @(negedge clk) begin
      prev_valid <= bus.o_rx_valid;
      if (bus.o_rx_valid) begin
         rx_q.push_back(bus.o_rx_data);
         if (prev_valid) wide_pulses <= wide_pulses + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic m_take(output logic [7:0] v);
      v = m_full ? m_buf : 8'h00;
      if (!m_full) m_underrun = 1'b1;
      m_full = 1'b0;
   endtask

   task automatic host_load(input logic [7:0] d);
      @(negedge clk);
      bus.i_tx_data = d;
      bus.i_tx_load = 1'b1;
      @(negedge clk);
      bus.i_tx_load = 1'b0;
      if (!m_full) begin
         m_buf      = d;
         m_full     = 1'b1;
         m_underrun = 1'b0;
      end
      check("tx_ready after load", bus.o_tx_ready, !m_full);
   endtask

   task automatic half_wait(input bit ld, input logic [7:0] v);
      if (ld) begin
         host_load(v);
         repeat (2) @(negedge clk);
      end else begin
         repeat (4) @(negedge clk);
      end
   endtask

   // Controller side: clock nbits bits MSB first; optional host load after first leading edge
   task automatic spi_bits(input logic [1:0] mode, input logic [7:0] mosi, input int nbits,
                           input bit ld, input logic [7:0] ldv, output logic [7:0] miso);
      logic cpol;
      logic cpha;
      cpol = mode[1];
      cpha = mode[0];
      miso = 8'h00;
      for (int i = 7; i > 7 - nbits; i--) begin
         if (!cpha) begin
            bus.i_copi = mosi[i];
            half_wait(1'b0, 8'h00);
            miso[i]    = bus.o_cipo;
            bus.i_sclk = ~cpol;
            half_wait(ld && (i == 7), ldv);
            bus.i_sclk = cpol;
         end else begin
            bus.i_sclk = ~cpol;
            bus.i_copi = mosi[i];
            half_wait(ld && (i == 7), ldv);
            miso[i]    = bus.o_cipo;
            bus.i_sclk = cpol;
            half_wait(1'b0, 8'h00);
         end
      end
   endtask

   task automatic cs_begin(input logic [1:0] mode);
      @(negedge clk);
      bus.i_mode = mode;
      bus.i_sclk = mode[1];
      repeat (8) @(negedge clk);
      bus.i_cs_n = 1'b0;
      m_take(m_slot);
      repeat (8) @(negedge clk);
      check("busy in frame", bus.o_busy, 1'b1);
      check("cipo_oe in frame", bus.o_cipo_oe, 1'b1);
   endtask

   task automatic cs_end();
      repeat (4) @(negedge clk);
      bus.i_cs_n = 1'b1;
      repeat (8) @(negedge clk);
      check("busy after frame", bus.o_busy, 1'b0);
      check("cipo_oe after frame", bus.o_cipo_oe, 1'b0);
      check("no stray rx_valid", rx_q.size(), 0);
      rx_q.delete();
   endtask

   task automatic do_byte(input logic [1:0] mode, input logic [7:0] mosi, input bit ld,
                          input logic [7:0] ldv, input string tag);
      logic [7:0] got;
      logic [7:0] got_rx;
      spi_bits(mode, mosi, 8, ld, ldv, got);
      check({tag, " cipo byte"}, got, m_slot);
      m_rx_data = mosi;
      check({tag, " rx_valid count"}, rx_q.size(), 1);
      got_rx = (rx_q.size() > 0) ? rx_q[0] : 8'hxx;
      check({tag, " rx pulse data"}, got_rx, mosi);
      check({tag, " rx_data hold"}, bus.o_rx_data, m_rx_data);
      rx_q.delete();
      m_take(m_slot);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " cipo"}, bus.o_cipo, 1'b0);
      check({tag, " cipo_oe"}, bus.o_cipo_oe, 1'b0);
      check({tag, " tx_ready"}, bus.o_tx_ready, 1'b1);
      check({tag, " rx_data"}, bus.o_rx_data, 8'h00);
      check({tag, " rx_valid"}, bus.o_rx_valid, 1'b0);
      check({tag, " busy"}, bus.o_busy, 1'b0);
`ifdef SPI_PERIPHERAL_UNDERRUN_EN
      check({tag, " underrun"}, bus.o_tx_underrun, 1'b0);
`endif
   endtask

   initial begin
      logic [7:0] got;
      logic [1:0] mode;
      int         nb;

      rst           = 1'b1;
      bus.i_mode    = 2'b00;
      bus.i_sclk    = 1'b0;
      bus.i_cs_n    = 1'b1;
      bus.i_copi    = 1'b0;
      bus.i_tx_data = 8'h00;
      bus.i_tx_load = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;
      repeat (8) @(negedge clk);

      // Mode 0 single byte
      host_load(8'h3C);
      cs_begin(2'd0);
      do_byte(2'd0, 8'hA5, 1'b0, 8'h00, "mode0");
      cs_end();

      // Modes 1..3
      for (int m = 1; m < 4; m++) begin
         host_load(8'hC3);
         cs_begin(m[1:0]);
         do_byte(m[1:0], 8'h5A, 1'b0, 8'h00, $sformatf("mode%0d", m));
         cs_end();
      end

      // Two bytes in one chip-select assertion, buffer refilled during byte 1
      host_load(8'h81);
      cs_begin(2'd0);
      do_byte(2'd0, 8'h11, 1'b1, 8'h42, "b2b first");
      do_byte(2'd0, 8'h22, 1'b0, 8'h00, "b2b second");
      cs_end();

      // Abort after 4 sclk edges
      cs_begin(2'd0);
      spi_bits(2'd0, 8'hFF, 2, 1'b0, 8'h00, got);
      cs_end();
      check("abort rx_data unchanged", bus.o_rx_data, m_rx_data);
      host_load(8'h6E);
      cs_begin(2'd0);
      do_byte(2'd0, 8'hF0, 1'b0, 8'h00, "after abort");
      cs_end();

      // Reset mid-byte
      host_load(8'h55);
      cs_begin(2'd1);
      spi_bits(2'd1, 8'hE7, 3, 1'b0, 8'h00, got);
      @(posedge clk);
      #2 rst = 1'b1;
      #1 check_reset_outputs("async reset");
      repeat (3) @(negedge clk);
      bus.i_cs_n = 1'b1;
      bus.i_sclk = 1'b0;
      bus.i_copi = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      m_full     = 1'b0;
      m_rx_data  = 8'h00;
      m_underrun = 1'b0;
      rx_q.delete();
      repeat (8) @(negedge clk);
      host_load(8'($urandom));
      cs_begin(2'd0);
      do_byte(2'd0, 8'h96, 1'b0, 8'h00, "after reset");
      cs_end();

`ifdef SPI_PERIPHERAL_UNDERRUN_EN
      // Frame with nothing loaded
      cs_begin(2'd0);
      check("underrun set", bus.o_tx_underrun, m_underrun);
      do_byte(2'd0, 8'h3A, 1'b0, 8'h00, "underrun");
      cs_end();
      check("underrun sticky", bus.o_tx_underrun, 1'b1);
      host_load(8'h77);
      check("underrun cleared", bus.o_tx_underrun, m_underrun);
`endif

      // Randomized frames
      for (int it = 0; it < 16; it++) begin
         mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) host_load(8'($urandom));
         cs_begin(mode);
         nb = $urandom_range(1, 3);
         for (int k = 0; k < nb; k++)
            do_byte(mode, 8'($urandom), 1'($urandom_range(0, 1)), 8'($urandom),
                    $sformatf("rand%0d.%0d", it, k));
         cs_end();
`ifdef SPI_PERIPHERAL_UNDERRUN_EN
         check("rand underrun", bus.o_tx_underrun, m_underrun);
`endif
      end

      check("rx_valid single cycle", wide_pulses, 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
`default_nettype wire
